// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - round-robin two-port arbiter and sequencer for a shared 8-bit ALU
`timescale 1ns/1ps
module alu_arbiter #(
  parameter int MUL_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [7:0]  req0_a,
  input  logic [7:0]  req0_b,
  input  logic [1:0]  req0_op,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [7:0]  req1_a,
  input  logic [7:0]  req1_b,
  input  logic [1:0]  req1_op,
  output logic [7:0]  alu_a,
  output logic [7:0]  alu_b,
  output logic [1:0]  alu_op,
  input  logic [15:0] alu_result,
  input  logic        alu_zflag,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [15:0] rsp_result,
  output logic        rsp_zflag,
  output logic        busy,
  output logic [15:0] op_count
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [3:0] MUL_LOAD = 4'(MUL_CYCLES - 1);

  logic [1:0]  state_q, state_d;
  logic [7:0]  alu_a_q, alu_a_d;
  logic [7:0]  alu_b_q, alu_b_d;
  logic [1:0]  alu_op_q, alu_op_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        cur_id_q, cur_id_d;
  logic        last_id_q, last_id_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic        rsp_id_q, rsp_id_d;
  logic [15:0] rsp_result_q, rsp_result_d;
  logic        rsp_zflag_q, rsp_zflag_d;
  logic [15:0] op_count_q, op_count_d;

  logic gnt0, gnt1;
  logic [1:0] sel_op;

  // On a tie the requester that did not complete last wins.
  assign gnt0 = req0_valid && (!req1_valid || last_id_q);
  assign gnt1 = req1_valid && (!req0_valid || !last_id_q);

  assign req0_ready = (state_q == IDLE) && gnt0;
  assign req1_ready = (state_q == IDLE) && gnt1;
  assign sel_op     = req1_ready ? req1_op : req0_op;

  always_comb begin
    state_d      = state_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    alu_op_d     = alu_op_q;
    cnt_d        = cnt_q;
    cur_id_d     = cur_id_q;
    last_id_d    = last_id_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_id_d     = rsp_id_q;
    rsp_result_d = rsp_result_q;
    rsp_zflag_d  = rsp_zflag_q;
    op_count_d   = op_count_q;
    case (state_q)
      IDLE: begin
        if (req0_ready || req1_ready) begin
          alu_a_d  = req1_ready ? req1_a : req0_a;
          alu_b_d  = req1_ready ? req1_b : req0_b;
          alu_op_d = sel_op;
          cur_id_d = req1_ready;
          cnt_d    = (sel_op == OP_MUL) ? MUL_LOAD : 4'd0;
          state_d  = EXEC;
        end
      end
      EXEC: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          rsp_result_d = alu_result;
          rsp_zflag_d  = alu_zflag;
          rsp_id_d     = cur_id_q;
          rsp_valid_d  = 1'b1;
          state_d      = DONE;
        end
      end
      DONE: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          last_id_d   = rsp_id_q;
          op_count_d  = op_count_q + 16'd1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      alu_a_q      <= 8'd0;
      alu_b_q      <= 8'd0;
      alu_op_q     <= 2'd0;
      cnt_q        <= 4'd0;
      cur_id_q     <= 1'b0;
      last_id_q    <= 1'b1;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_result_q <= 16'd0;
      rsp_zflag_q  <= 1'b0;
      op_count_q   <= 16'd0;
    end else begin
      state_q      <= state_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      alu_op_q     <= alu_op_d;
      cnt_q        <= cnt_d;
      cur_id_q     <= cur_id_d;
      last_id_q    <= last_id_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_result_q <= rsp_result_d;
      rsp_zflag_q  <= rsp_zflag_d;
      op_count_q   <= op_count_d;
    end
  end

  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_op     = alu_op_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_id     = rsp_id_q;
  assign rsp_result = rsp_result_q;
  assign rsp_zflag  = rsp_zflag_q;
  assign busy       = (state_q != IDLE);
  assign op_count   = op_count_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - directed-vector bench for alu_arbiter with a behavioural ALU
`timescale 1ns/1ps
module tb_alu_arbiter;

  localparam int MUL_CYCLES = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_valid, req1_valid, req0_ready, req1_ready;
  logic [7:0]  req0_a, req0_b, req1_a, req1_b;
  logic [1:0]  req0_op, req1_op;
  logic [7:0]  alu_a, alu_b;
  logic [1:0]  alu_op;
  logic [15:0] alu_result;
  logic        alu_zflag;
  logic        rsp_valid, rsp_ready, rsp_id, rsp_zflag, busy;
  logic [15:0] rsp_result, op_count;

  int n_checks = 0;
  int n_pass = 0;
  int exp_count = 0;

  alu_arbiter #(.MUL_CYCLES(MUL_CYCLES)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_result(alu_result), .alu_zflag(alu_zflag),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_result(rsp_result),
    .rsp_zflag(rsp_zflag), .busy(busy), .op_count(op_count)
  );

  always #5 clk = ~clk;

  always_comb begin
    alu_result = 16'd0;
    case (alu_op)
      2'b00: alu_result = {8'd0, alu_a} + {8'd0, alu_b};
      2'b01: alu_result = {8'd0, alu_a} - {8'd0, alu_b};
      2'b10: alu_result = {8'd0, alu_a} * {8'd0, alu_b};
      default: alu_result = {7'd0, alu_a, 1'b0};
    endcase
  end
  assign alu_zflag = (alu_result == 16'd0);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic do_op(input bit id, input logic [7:0] a, input logic [7:0] b, input logic [1:0] op,
                       input logic [15:0] res, input bit z, input int lat);
    int n;
    @(negedge clk);
    if (id) begin req1_valid = 1'b1; req1_a = a; req1_b = b; req1_op = op; end
    else    begin req0_valid = 1'b1; req0_a = a; req0_b = b; req0_op = op; end
    #1;
    check("grant", 32'({req1_ready, req0_ready}), id ? 32'd2 : 32'd1);
    @(negedge clk);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    check("exec_hold", 32'({busy, alu_a, alu_b, alu_op}), 32'({1'b1, a, b, op}));
    n = 0;
    while (!rsp_valid && n < 40) begin @(negedge clk); n++; end
    check("latency", 32'(n), 32'(lat));
    check("rsp", 32'({rsp_id, rsp_zflag, rsp_result}), 32'({id, z, res}));
    @(negedge clk);
    exp_count++;
    check("op_count", 32'({busy, rsp_valid, op_count}), 32'({2'b00, 16'(exp_count)}));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    bit seen;
    rst_n = 1'b0; rsp_ready = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_a = '0; req0_b = '0; req0_op = '0; req1_a = '0; req1_b = '0; req1_op = '0;
    repeat (2) @(negedge clk);
    check("rst_alu", 32'({alu_a, alu_b, alu_op}), 32'd0);
    check("rst_rsp", 32'({rsp_valid, rsp_id, rsp_zflag, rsp_result, busy}), 32'd0);
    check("rst_count", 32'(op_count), 32'd0);
    rst_n = 1'b1;

    do_op(1'b0, 8'h05, 8'h03, 2'b00, 16'h0008, 1'b0, 1);
    do_op(1'b1, 8'hFF, 8'hFF, 2'b10, 16'hFE01, 1'b0, 3);
    do_op(1'b0, 8'h07, 8'h07, 2'b01, 16'h0000, 1'b1, 1);
    do_op(1'b1, 8'h03, 8'h05, 2'b01, 16'hFFFE, 1'b0, 1);
    do_op(1'b0, 8'h0C, 8'h0D, 2'b10, 16'h009C, 1'b0, 3);
    do_op(1'b1, 8'h80, 8'h00, 2'b11, 16'h0100, 1'b0, 1);

    // Round robin with both requesters valid throughout.
    @(negedge clk);
    req0_a = 8'h01; req0_b = 8'h01; req0_op = 2'b00;
    req1_a = 8'h02; req1_b = 8'h02; req1_op = 2'b00;
    req0_valid = 1'b1; req1_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n = 0;
      #1;
      while (!(req0_ready || req1_ready) && n < 20) begin @(negedge clk); #1; n++; end
      check("rr_onehot", 32'(req0_ready & req1_ready), 32'd0);
      check("rr_grant", 32'({req1_ready, req0_ready}), (i % 2) ? 32'd2 : 32'd1);
      @(negedge clk);
      n = 0;
      while (!rsp_valid && n < 20) begin @(negedge clk); n++; end
      check("rr_rsp", 32'({rsp_valid, rsp_id, rsp_result}), 32'({1'b1, 1'(i % 2), (i % 2) ? 16'h0004 : 16'h0002}));
      if (i == 3) begin req0_valid = 1'b0; req1_valid = 1'b0; end
      exp_count++;
    end
    @(negedge clk);
    check("rr_count", 32'(op_count), 32'(exp_count));

    // Backpressure: response held, no grants while stalled in DONE.
    @(negedge clk);
    rsp_ready = 1'b0;
    req0_a = 8'h10; req0_b = 8'h20; req0_op = 2'b00;
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    check("bp_grant", 32'({req1_ready, req0_ready}), 32'd1);
    @(negedge clk);
    n = 0;
    while (!rsp_valid && n < 20) begin @(negedge clk); n++; end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); #1;
      check("bp_hold", 32'({rsp_valid, rsp_id, rsp_zflag, rsp_result, busy, req0_ready, req1_ready}),
            32'({1'b1, 1'b0, 1'b0, 16'h0030, 1'b1, 1'b0, 1'b0}));
    end
    req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b1;
    exp_count++;
    @(negedge clk);
    check("bp_release", 32'({busy, rsp_valid, op_count}), 32'({2'b00, 16'(exp_count)}));
    repeat (2) @(negedge clk);
    check("bp_once", 32'(op_count), 32'(exp_count));

    // Reset in the middle of a multiply.
    @(negedge clk);
    req1_a = 8'h03; req1_b = 8'h04; req1_op = 2'b10; req1_valid = 1'b1;
    @(negedge clk);
    req1_valid = 1'b0;
    check("mr_exec", 32'(busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("mr_alu", 32'({alu_a, alu_b, alu_op}), 32'd0);
    check("mr_rsp", 32'({rsp_valid, rsp_id, rsp_zflag, rsp_result, busy}), 32'd0);
    check("mr_count", 32'(op_count), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (rsp_valid || busy) seen = 1'b1;
    end
    check("mr_no_rsp", 32'(seen), 32'd0);
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    check("mr_tie", 32'({req1_ready, req0_ready}), 32'd1);
    @(negedge clk);
    req0_valid = 1'b0; req1_valid = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Two-port arbiter and sequencer for the shared 8-bit ALU (add, sub, mul, shift-left-by-1; 16-bit result, zero flag). It accepts operations from two requesters over valid/ready handshakes and grants them round-robin. It drives the ALU operand and opcode inputs from registers, waits a fixed number of execute cycles per opcode, and returns the captured result and zero flag on a shared response channel tagged with the requester ID.

## Interface
- MUL_CYCLES, default 2: execute cycles for opcode 2'b10 (multiply). Legal range 1..15. All other opcodes take 1 cycle.
- clk  input  1  system clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req0_valid, req1_valid  input  1 each  requester has an operation pending.
- req0_ready, req1_ready  output  1 each  the operation is accepted this cycle (combinational).
- req0_a, req0_b, req1_a, req1_b  input  8 each  operands.
- req0_op, req1_op  input  2 each  opcode: 00 add, 01 sub, 10 mul, 11 A<<1.
- alu_a, alu_b  output  8 each  registered operands to the ALU.
- alu_op  output  2  registered opcode to the ALU.
- alu_result  input  16  combinational ALU result.
- alu_zflag  input  1  combinational ALU zero flag.
- rsp_valid  output  1  response is held and available.
- rsp_ready  input  1  consumer accepts the response.
- rsp_id  output  1  requester that issued the operation.
- rsp_result  output  16  captured result.
- rsp_zflag  output  1  captured zero flag.
- busy  output  1  high in the EXEC and DONE states.
- op_count  output  16  number of completed responses; wraps from 0xFFFF to 0.

## Operation
- FSM states: IDLE, EXEC, DONE.
- IDLE
  - Arbitration: if exactly one reqN_valid is high, grant it. If both are high, grant the requester that is not `last_id`.
  - reqN_ready = (state==IDLE) && granted. Outputs are combinational and only one is ever high.
  - On handshake: register a, b and op into alu_a/alu_b/alu_op. Register the ID into `cur_id`. Load `cnt` with MUL_CYCLES-1 if op==10, otherwise 0. Go to EXEC.
- EXEC
  - alu_a, alu_b and alu_op are held stable.
  - If cnt != 0: decrement cnt.
  - If cnt == 0: capture alu_result into rsp_result and alu_zflag into rsp_zflag, set rsp_id=cur_id, set rsp_valid=1, and go to DONE.
- DONE
  - rsp_valid, rsp_id, rsp_result and rsp_zflag are held until rsp_ready is seen.
  - On rsp_ready: clear rsp_valid, set last_id=rsp_id, increment op_count, and go to IDLE.
- No new request is accepted outside IDLE; req*_ready is 0 in EXEC and DONE.
- Requesters must hold valid and payload stable until ready. Dropping valid without ready is tolerated; nothing is accepted in that case.
- Width rules:
  - Sub wraps modulo 2^16 as produced by the ALU; e.g. 3-5 = 0xFFFE.
  - Mul is the full 16-bit product.
  - A<<1 gives a 9-bit value zero-extended to 16 bits.
  - The block never modifies alu_result.
- Reset (asynchronous, rst_n low):
  - State goes to IDLE.
  - alu_a=0, alu_b=0, alu_op=0, cnt=0, cur_id=0, last_id=1 (so requester 0 wins the first tie).
  - rsp_valid=0, rsp_id=0, rsp_result=0, rsp_zflag=0, busy=0, op_count=0.
  - Reset mid-EXEC or mid-DONE discards the operation; no response is produced.

## Timing
- Handshake at edge T0 (IDLE, valid&&ready). EXEC occupies the cycles from T0 to T0+E, where E=1 for non-mul ops and E=MUL_CYCLES for mul.
- rsp_valid rises after edge T0+E. With rsp_ready held high, state returns to IDLE after edge T0+E+1.
- The next request can be accepted at edge T0+E+2. Back-to-back throughput for non-mul ops is one operation per 3 cycles.
- rsp_ready low stalls in DONE indefinitely, with no limit.
- req_ready depends combinationally on req_valid and state only; there is no path from rsp_ready to req_ready.
- alu_result is sampled only at the edge where cnt==0 in EXEC. The ALU path must settle within one cycle.

## Test plan
- Reset then single add: req0 a=0x05 b=0x03 op=00 with rsp_ready=1 → req0_ready high in cycle 0; rsp_valid after 2 edges with rsp_result=0x0008, rsp_zflag=0, rsp_id=0; op_count=1.
- Multiply latency, MUL_CYCLES=3: req1 a=0xFF b=0xFF op=10 → rsp_valid exactly 3 edges after the handshake, rsp_result=0xFE01, rsp_id=1.
- Zero/wrap check:
  - sub a=0x07 b=0x07 → result 0, zflag=1.
  - sub a=0x03 b=0x05 → result 0xFFFE, zflag=0.
  - shift a=0x80 → result 0x0100.
- Round-robin: both valid continuously for 4 ops → grant order 0,1,0,1; rsp_id matches each; never two readys at once.
- Backpressure: hold rsp_ready=0 for 10 cycles in DONE → rsp_* stable, busy=1, both req*_ready=0. Release → one handshake, op_count increments once.
- Reset mid-operation: assert rst_n=0 during EXEC of a mul → all outputs immediately at reset values, no rsp_valid afterwards; the next tie grants requester 0.
